// File: rtl/ctr_pkg.sv
// Shared definitions for the ctr_mod counter family: direction encoding and
// parameter legality check used at elaboration.
package ctr_pkg;

  typedef enum logic {
    CTR_DN = 1'b0,
    CTR_UP = 1'b1
  } ctr_dir_e;

  // True when WIDTH/MODULUS/RESET_VAL describe a realisable counter.
  function automatic bit ctr_params_ok(input int unsigned     width,
                                       input longint unsigned modulus,
                                       input longint unsigned reset_val);
    if (width < 1 || width > 32) return 1'b0;
    if (modulus < 64'd2) return 1'b0;
    if (modulus > (64'd1 << width)) return 1'b0;
    if (reset_val >= modulus) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/ctr_mod_step.sv
// Combinational successor and terminal-count detect for ctr_mod.
// Terminal behaviour selected by CTR_SAT_EN (defined: saturate, else wrap).
module ctr_mod_step
  import ctr_pkg::*;
#(
  parameter int          WIDTH   = 6,
  parameter int unsigned MODULUS = 64
) (
  input  logic [WIDTH-1:0] out,
  input  logic             up,
  output logic             at_term,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] TOP_W = MOD_W - 1'b1;

  logic [WIDTH:0] cur;
  logic [WIDTH:0] term;

  always_comb begin
    cur     = {1'b0, out};
    term    = (up == CTR_UP) ? TOP_W : '0;
    at_term = (cur == term);
    // Off-terminal the step cannot leave 0..MODULUS-1, so WIDTH bits suffice.
    if (!at_term) begin
      nxt = (up == CTR_UP) ? out + 1'b1 : out - 1'b1;
    end else begin
`ifdef CTR_SAT_EN
      nxt = out;
`else
      nxt = (up == CTR_UP) ? '0 : TOP_W[WIDTH-1:0];
`endif
    end
  end

endmodule

// File: rtl/ctr_mod.sv
// Loadable up/down modulo counter with terminal count, event pulse and sticky
// overflow. Define CTR_SAT_EN to saturate at the terminal value instead of wrapping.
module ctr_mod
  import ctr_pkg::*;
#(
  parameter int          WIDTH     = 6,
  parameter int unsigned MODULUS   = 64,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             evt,
  output logic             ovf
);

  if (!ctr_params_ok(WIDTH, longint'(MODULUS), longint'(RESET_VAL))) begin : g_bad_params
    $error("ctr_mod: illegal WIDTH/MODULUS/RESET_VAL combination");
  end

  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] TOP_W = MOD_W - 1'b1;

  logic             at_term;
  logic [WIDTH-1:0] step_nxt;
  logic             wrap_evt;
  logic             bad_ld;
  logic [WIDTH-1:0] out_nxt;

  ctr_mod_step #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_step (
    .out    (out),
    .up     (up),
    .at_term(at_term),
    .nxt    (step_nxt)
  );

  always_comb begin
    wrap_evt = en & ~ld & at_term;
    bad_ld   = ld & ({1'b0, din} >= MOD_W);
    tc       = en & ~ld & ~clr & at_term;
    if (ld) begin
      out_nxt = bad_ld ? TOP_W[WIDTH-1:0] : din;
    end else if (en) begin
      out_nxt = step_nxt;
    end else begin
      out_nxt = out;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      out <= WIDTH'(RESET_VAL);
      evt <= 1'b0;
      ovf <= 1'b0;
    end else begin
      out <= out_nxt;
      evt <= wrap_evt;
      // A set condition overrides a coincident ovf_clr.
      ovf <= wrap_evt | bad_ld | (ovf & ~ovf_clr);
    end
  end

endmodule
